// File: rtl/zxv_pkg.sv
// Shared constants and types for the ZX video pixel path.
// Attribute field positions and the {G,R,B} colour encoding.
package zxv_pkg;

  localparam int ATTR_INK_LSB   = 0;
  localparam int ATTR_PAPER_LSB = 3;
  localparam int ATTR_BRIGHT    = 6;
  localparam int ATTR_FLASH     = 7;

  typedef logic [2:0] zxv_color_t;

  localparam zxv_color_t BLACK   = 3'd0;
  localparam zxv_color_t BLUE    = 3'd1;
  localparam zxv_color_t RED     = 3'd2;
  localparam zxv_color_t MAGENTA = 3'd3;
  localparam zxv_color_t GREEN   = 3'd4;
  localparam zxv_color_t CYAN    = 3'd5;
  localparam zxv_color_t YELLOW  = 3'd6;
  localparam zxv_color_t WHITE   = 3'd7;

  function automatic zxv_color_t attr_ink(input logic [7:0] attr);
    return attr[ATTR_INK_LSB +: 3];
  endfunction

  function automatic zxv_color_t attr_paper(input logic [7:0] attr);
    return attr[ATTR_PAPER_LSB +: 3];
  endfunction

endpackage

// File: rtl/zxv_shifter.sv
// Parallel-load / shift-left pixel register, MSB first.
// msb_nxt is the MSB this cycle will leave behind, for same-edge colour decode.
module zxv_shifter #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             load,
  input  logic [PIX_W-1:0] par_d,
  output logic             msb,
  output logic             msb_nxt
);

  logic [PIX_W-1:0] shift_q;
  logic [PIX_W-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (ce) begin
      if (load) shift_d = par_d;
      else      shift_d = {shift_q[PIX_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) shift_q <= '0;
    else       shift_q <= shift_d;
  end

  assign msb     = shift_q[PIX_W-1];
  assign msb_nxt = shift_d[PIX_W-1];

endmodule

// File: rtl/zx_pixel_serializer.sv
// ZX pixel/attribute double buffer, serialiser and RGBI colour decode.
// Define ZXV_FLASH_EN to build the frame counter and flash inversion.
module zx_pixel_serializer
  import zxv_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int FLASH_DIV_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             pix_ce,
  input  logic [PIX_W-1:0] pix_d,
  input  logic             pix_ld,
  input  logic [7:0]       attr_d,
  input  logic             attr_ld,
  input  logic             load,
  input  logic             active,
  input  logic [2:0]       border,
  input  logic             frame_sync,
  output logic             R,
  output logic             G,
  output logic             B,
  output logic             I
);

  logic [PIX_W-1:0] pix_hold_q,  pix_hold_d;
  logic [7:0]       attr_hold_q, attr_hold_d;
  logic [7:0]       attr_stg_q,  attr_stg_d;
  logic             active_stg_q, active_stg_d;
  zxv_color_t       color_q, color_d;
  logic             inten_q, inten_d;
  logic             shift_msb, shift_msb_nxt;
  logic             flash_phase;
  logic             px;

  zxv_shifter #(.PIX_W(PIX_W)) u_shifter (
    .clk     (CLK),
    .reset   (RESET),
    .ce      (pix_ce),
    .load    (load),
    .par_d   (pix_hold_q),
    .msb     (shift_msb),
    .msb_nxt (shift_msb_nxt)
  );

`ifdef ZXV_FLASH_EN
  logic [FLASH_DIV_W-1:0] flash_cnt_q, flash_cnt_d;

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (frame_sync) flash_cnt_d = flash_cnt_q + FLASH_DIV_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) flash_cnt_q <= '0;
    else       flash_cnt_q <= flash_cnt_d;
  end

  // Registered phase: a frame_sync on a pix_ce cycle only affects later pixels.
  assign flash_phase = flash_cnt_q[FLASH_DIV_W-1];
`else
  assign flash_phase = 1'b0;
`endif

  logic unused_sig;
  assign unused_sig = ^{frame_sync, shift_msb};

  always_comb begin
    pix_hold_d  = pix_ld  ? pix_d  : pix_hold_q;
    attr_hold_d = attr_ld ? attr_d : attr_hold_q;

    attr_stg_d   = attr_stg_q;
    active_stg_d = active_stg_q;
    if (pix_ce && load) begin
      attr_stg_d   = attr_hold_q;
      active_stg_d = active;
    end
  end

  // Decode from the post-update stage so a loaded byte shows on the next CLK.
  always_comb begin
    px      = shift_msb_nxt ^ (attr_stg_d[ATTR_FLASH] & flash_phase);
    color_d = color_q;
    inten_d = inten_q;
    if (pix_ce) begin
      if (active_stg_d) begin
        color_d = px ? attr_ink(attr_stg_d) : attr_paper(attr_stg_d);
        inten_d = attr_stg_d[ATTR_BRIGHT];
      end else begin
        color_d = border;
        inten_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pix_hold_q   <= '0;
      attr_hold_q  <= '0;
      attr_stg_q   <= '0;
      active_stg_q <= 1'b0;
      color_q      <= BLACK;
      inten_q      <= 1'b0;
    end else begin
      pix_hold_q   <= pix_hold_d;
      attr_hold_q  <= attr_hold_d;
      attr_stg_q   <= attr_stg_d;
      active_stg_q <= active_stg_d;
      color_q      <= color_d;
      inten_q      <= inten_d;
    end
  end

  assign G = color_q[2];
  assign R = color_q[1];
  assign B = color_q[0];
  assign I = inten_q;

endmodule

// File: doc/zx_pixel_serializer.md
Name: zx_pixel_serializer

Overview:
- Parametrised successor to the fixed 8-bit pixel/attribute latch-and-shift path of the ZX video block.
- Double-buffers pixel and attribute bytes, serialises pixels at a pixel-clock enable, and decodes the attribute (ink/paper/bright/flash) into registered R, G, B, I.
- Outputs the border colour outside the active area.
- Sits between the video memory fetch sequencer (strobes) and the RGBI DAC/output pins.

Parameters:
- PIX_W, 8: bits per pixel fetch; shifter width. Legal values 4..16.
- FLASH_DIV_W, 5: frame counter width. The flash phase is the counter MSB, so it toggles every 2^(FLASH_DIV_W-1) frames (16 at the default).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- pix_ce  in  1  pixel clock enable; one pixel per asserted cycle.
- pix_d  in  PIX_W  pixel byte from memory; MSB is displayed first.
- pix_ld  in  1  latch pix_d into the pixel holding register.
- attr_d  in  8  attribute byte: [2:0] ink, [5:3] paper, [6] bright, [7] flash.
- attr_ld  in  1  latch attr_d into the attribute holding register.
- load  in  1  transfer the holding registers to the shift stage; sampled only when pix_ce=1.
- active  in  1  display-area flag; sampled together with load.
- border  in  3  border colour, {G,R,B}.
- frame_sync  in  1  one-cycle pulse per frame; advances the flash counter.
- R, G, B, I  out  1 each  registered colour outputs.

Behaviour:
- Reset: all registers are cleared on the first posedge with RESET=1. This covers the holding registers, shifter, attribute stage, active_q, flash counter, and R/G/B/I (all 0).
- RESET overrides every other input in the same cycle. Reset mid-line drops the current byte; output stays 0 until the first pix_ce after RESET deasserts.
- Holding stage: pix_ld=1 sets pix_hold<=pix_d. attr_ld=1 sets attr_hold<=attr_d. Both are independent of pix_ce.
- Shift stage, evaluated when pix_ce=1:
  - If load=1: shifter<=pix_hold, attr_q<=attr_hold, active_q<=active.
  - Otherwise: shifter<={shifter[PIX_W-2:0],1'b0}.
- With pix_ce=0, the shift stage holds.
- pix_ld and load in the same cycle: the shifter receives the OLD pix_hold and pix_hold takes the new value. The same rule applies to attr_ld with load.
- If no load arrives after PIX_W shifts, zeros shift out, so paper is shown. This is not an error.
- Pixel bit: px = shifter[PIX_W-1] XOR (attr_q[7] AND flash_phase).
- Colour, registered on a pix_ce cycle, evaluated from the post-update shift stage (the values written this cycle):
  - active_q=1: {G,R,B} = px ? attr_q[2:0] : attr_q[5:3], and I = attr_q[6].
  - active_q=0: {G,R,B} = border, and I = 0.
- Latency: the first pixel of a loaded byte appears on R/G/B/I one CLK after the pix_ce cycle that carried load. Outputs hold between pix_ce cycles.
- Flash counter: increments by 1 on frame_sync=1, mod 2^FLASH_DIV_W, wrapping all-ones->0. flash_phase = cnt[FLASH_DIV_W-1].
- frame_sync coincident with pix_ce: the counter updates this cycle, but the new phase is used from the next pix_ce.

Optional Feature:
- ZXV_FLASH_EN defined: the flash counter and XOR are implemented as above.
- ZXV_FLASH_EN undefined:
  - attr bit 7 is ignored (px = shifter MSB);
  - the flash counter is not instantiated;
  - frame_sync is unused (port retained).

Decomposition:
- Package zxv_pkg holds:
  - attribute field constants (ATTR_INK_LSB=0, ATTR_PAPER_LSB=3, ATTR_BRIGHT=6, ATTR_FLASH=7);
  - a 3-bit colour typedef zxv_color_t with {G,R,B} ordering;
  - named colour constants (BLACK=0 .. WHITE=7).
- One sub-module, zxv_shifter: PIX_W parallel-load/shift-left register with ce, load, and MSB-out.

Test Plan:
- Basic pixel: pix_d=8'hA5, attr_d=8'h47 (ink 7, paper 0, bright), active=1, load on the next pix_ce. Required: GRB sequence 7,0,7,0,0,7,0,7 with I=1 on 8 consecutive pix_ce, first value one CLK after the load cycle.
- Border: active=0 at load, border=3'b010. Required: {G,R,B}=010 (R=1 only) and I=0 for all 8 pixels regardless of pix_d/attr_d.
- Flash: attr_d=8'h81 (flash, ink 1, paper 0), pix_d=8'hF0. After 16 frame_sync pulses (default width), the displayed pattern inverts (GRB 0,0,0,0,1,1,1,1). After 32 pulses it reverts. Without ZXV_FLASH_EN it never inverts.
- Same-cycle pix_ld+load: pix_hold=8'hFF, then pix_ld with pix_d=8'h00 in the same cycle as load. Required: the shifter shows 8'hFF this byte; the next load shows 8'h00.
- Missing load: after 8 pixels of 8'hFF with no further load, pixels 9..12 show paper colour.
- Reset mid-byte: assert RESET after 3 pixels. Required: R=G=B=I=0 on the next CLK, and the flash counter reads 0 afterwards.
